// File: rtl/fb_port_arbiter.sv
// Single-port frame buffer arbiter: write-priority grant between capture and readout ports.
// Optional read starvation guard enabled with FB_ARB_STARVE_GUARD_EN.
module fb_port_arbiter #(
    parameter int ADDR_MAX     = 19199,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_req_i,
    input  logic [14:0] wr_addr_i,
    input  logic [3:0]  wr_data_i,
    output logic        wr_gnt_o,
    input  logic        rd_req_i,
    input  logic [14:0] rd_addr_i,
    output logic        rd_gnt_o,
    output logic [3:0]  rd_data_o,
    output logic        rd_valid_o,
    output logic [14:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_wdata_o,
    input  logic [3:0]  ram_rdata_i,
    output logic [15:0] oor_cnt_o
);

    localparam logic [14:0] ADDR_MAX_L = 15'(ADDR_MAX);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    state_t      state_reg, state_next;
    logic        gnt_en_reg;
    logic        gnt_en;
    logic        rd_force;
    logic        wr_oor, rd_oor, oor_hit;
    logic [14:0] ram_addr_reg;
    logic [3:0]  ram_wdata_reg;
    logic [15:0] oor_cnt_reg;
    logic [1:0]  rd_vld_reg, rd_oor_reg;
    logic [1:0]  rd_vld_next, rd_oor_next;

    // Grants stay off through the reset cycle and the first cycle after it.
    assign gnt_en = rst_n_i & gnt_en_reg;
    assign wr_oor = (wr_addr_i > ADDR_MAX_L);
    assign rd_oor = (rd_addr_i > ADDR_MAX_L);

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    logic [CW-1:0] starve_reg, starve_next;

    assign rd_force = (starve_reg == CW'(STARVE_LIMIT));

    always_comb begin
        starve_next = starve_reg;
        if (!rd_req_i || rd_gnt_o)
            starve_next = '0;
        else if (starve_reg != CW'(STARVE_LIMIT))
            starve_next = starve_reg + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            starve_reg <= '0;
        else
            starve_reg <= starve_next;
    end
`else
    assign rd_force = 1'b0;
`endif

    assign wr_gnt_o = gnt_en & wr_req_i & ~(rd_force & rd_req_i);
    assign rd_gnt_o = gnt_en & rd_req_i & (~wr_req_i | rd_force);
    assign oor_hit  = (wr_gnt_o & wr_oor) | (rd_gnt_o & rd_oor);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Out-of-range accesses are granted but park the port in idle.
    always_comb begin
        state_next = S_IDLE;
        if (wr_gnt_o && !wr_oor)
            state_next = S_WR;
        else if (rd_gnt_o && !rd_oor)
            state_next = S_RD;
    end

    always_comb begin
        ram_we_o = (state_reg == S_WR);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            gnt_en_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            oor_cnt_reg   <= '0;
        end else begin
            gnt_en_reg <= 1'b1;
            if (wr_gnt_o && !wr_oor) begin
                ram_addr_reg  <= wr_addr_i;
                ram_wdata_reg <= wr_data_i;
            end else if (rd_gnt_o && !rd_oor) begin
                ram_addr_reg <= rd_addr_i;
            end
            if (oor_hit && (oor_cnt_reg != 16'hFFFF))
                oor_cnt_reg <= oor_cnt_reg + 16'd1;
        end
    end

    // Two-stage read return pipe: address goes out at n+1, RAM data lands at n+2.
    assign rd_vld_next = {rd_vld_reg[0], rd_gnt_o};
    assign rd_oor_next = {rd_oor_reg[0], rd_gnt_o & rd_oor};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_pipe
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    rd_vld_reg[gi] <= 1'b0;
                    rd_oor_reg[gi] <= 1'b0;
                end else begin
                    rd_vld_reg[gi] <= rd_vld_next[gi];
                    rd_oor_reg[gi] <= rd_oor_next[gi];
                end
            end
        end
    endgenerate

    assign rd_valid_o  = rd_vld_reg[1];
    assign rd_data_o   = (rd_vld_reg[1] && !rd_oor_reg[1]) ? ram_rdata_i : 4'h0;
    assign ram_addr_o  = ram_addr_reg;
    assign ram_wdata_o = ram_wdata_reg;
    assign oor_cnt_o   = oor_cnt_reg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed steps plus randomized traffic against
// a transaction-level model (priority rule, shadow memory, queue of due read returns).
module tb_fb_port_arbiter;

    localparam int ADDR_MAX     = 19199;
    localparam int STARVE_LIMIT = 4;
`ifdef FB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        wr_req_i = 1'b0;
    logic [14:0] wr_addr_i = '0;
    logic [3:0]  wr_data_i = '0;
    logic        wr_gnt_o;
    logic        rd_req_i = 1'b0;
    logic [14:0] rd_addr_i = '0;
    logic        rd_gnt_o;
    logic [3:0]  rd_data_o;
    logic        rd_valid_o;
    logic [14:0] ram_addr_o;
    logic        ram_we_o;
    logic [3:0]  ram_wdata_o;
    logic [3:0]  ram_rdata_i = '0;
    logic [15:0] oor_cnt_o;

    fb_port_arbiter #(.ADDR_MAX(ADDR_MAX), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .oor_cnt_o(oor_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Frame buffer stand-in: synchronous write, registered read.
    logic [3:0] ram_mem [0:32767];
    always @(posedge clk_i) begin
        if (ram_we_o) ram_mem[ram_addr_o] <= ram_wdata_o;
        ram_rdata_i <= ram_mem[ram_addr_o];
    end

    typedef struct { int unsigned due; logic [3:0] d; } ret_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned vld_seen = 0;

    logic [3:0]  shadow [0:32767];
    ret_t        rq [$];
    bit          armed = 1'b0;
    int          starve = 0;
    logic [15:0] m_oor = '0;
    logic [14:0] m_addr = '0;
    logic [3:0]  m_wdata = '0;
    bit          m_we = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit w, input logic [14:0] wa, input logic [3:0] wd,
                        input bit r, input logic [14:0] ra, output bit wg, output bit rg);
        bit ok, frc, ewg, erg, exp_v;
        logic [3:0] exp_d;
        ret_t e;
        wr_req_i = w; wr_addr_i = wa; wr_data_i = wd;
        rd_req_i = r; rd_addr_i = ra;
        #1;
        ok  = rst_n_i && armed;
        frc = GUARD && (starve == STARVE_LIMIT);
        ewg = ok && w && !(frc && r);
        erg = ok && r && (!w || frc);
        wg = wr_gnt_o; rg = rd_gnt_o;
        chk("wr_gnt", 32'(wr_gnt_o), 32'(ewg));
        chk("rd_gnt", 32'(rd_gnt_o), 32'(erg));
        m_we = 1'b0;
        if (!rst_n_i) begin
            armed = 1'b0; starve = 0; m_oor = '0; m_addr = '0; m_wdata = '0;
            rq.delete();
        end else begin
            armed = 1'b1;
            if (ewg) begin
                if (int'(wa) > ADDR_MAX) begin
                    if (m_oor != 16'hFFFF) m_oor++;
                end else begin
                    m_we = 1'b1; m_addr = wa; m_wdata = wd; shadow[wa] = wd;
                end
            end
            if (erg) begin
                e.due = cyc + 2;
                if (int'(ra) > ADDR_MAX) begin
                    if (m_oor != 16'hFFFF) m_oor++;
                    e.d = 4'h0;
                end else begin
                    m_addr = ra; e.d = shadow[ra];
                end
                rq.push_back(e);
            end
            if (GUARD) starve = (!r || erg) ? 0 : ((starve < STARVE_LIMIT) ? starve + 1 : starve);
        end
        @(posedge clk_i); cyc++; #1;
        chk("ram_we", 32'(ram_we_o), 32'(m_we));
        chk("ram_addr", 32'(ram_addr_o), 32'(m_addr));
        chk("ram_wdata", 32'(ram_wdata_o), 32'(m_wdata));
        chk("oor_cnt", 32'(oor_cnt_o), 32'(m_oor));
        exp_v = 1'b0; exp_d = 4'h0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_v = 1'b1; exp_d = rq[0].d; void'(rq.pop_front());
        end
        chk("rd_valid", 32'(rd_valid_o), 32'(exp_v));
        chk("rd_data", 32'(rd_data_o), 32'(exp_d));
        if (rd_valid_o === 1'b1) vld_seen++;
        $display("cyc %0d wr=%0b/%0b rd=%0b/%0b we=%0b addr=%0d vld=%0b data=%0h oor=%0d",
                 cyc, w, wg, r, rg, ram_we_o, ram_addr_o, rd_valid_o, rd_data_o, oor_cnt_o);
    endtask

    task automatic idle(input int n);
        bit wg, rg;
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, wg, rg);
    endtask

    task automatic do_write(input logic [14:0] a, input logic [3:0] d);
        bit wg, rg, done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(1, a, d, 0, '0, wg, rg);
            done = wg;
        end
        chk("write_grant_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_read(input logic [14:0] a);
        bit wg, rg, done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(0, '0, '0, 1, a, wg, rg);
            done = rg;
        end
        chk("read_grant_timeout", 32'(done), 32'd1);
    endtask

    function automatic logic [14:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 15'($urandom_range(ADDR_MAX + 1, 32767));
        return 15'($urandom_range(0, ADDR_MAX));
    endfunction

    initial begin
        bit wg, rg, wp, rp;
        logic [14:0] wa, ra;
        logic [3:0] wd;
        int first_rd;
        int unsigned v0;

        // Reset held two cycles with requests pending, then the blanking cycle.
        rst_n_i = 1'b0;
        step(1, 15'd5, 4'h3, 1, 15'd6, wg, rg);
        step(1, 15'd5, 4'h3, 1, 15'd6, wg, rg);
        rst_n_i = 1'b1;
        step(1, 15'd5, 4'h3, 0, '0, wg, rg);
        chk("post_reset_wr_blank", 32'(wg), 32'd0);
        idle(1);

        // Write 100 <- A then read it back.
        do_write(15'd100, 4'hA);
        idle(1);
        do_read(15'd100);
        idle(2);

        // Simultaneous requests: write wins, read follows when write drops.
        step(1, 15'd101, 4'h5, 1, 15'd100, wg, rg);
        chk("both_req_wr_wins", 32'(wg), 32'd1);
        step(0, '0, '0, 1, 15'd100, wg, rg);
        chk("rd_after_wr_drop", 32'(rg), 32'd1);
        idle(3);

        // Both held ten cycles; writes advance address only when granted.
        first_rd = -1; wa = 15'd200; wd = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step(1, wa, wd, 1, 15'd100, wg, rg);
            if (rg && first_rd < 0) first_rd = i;
            if (wg) begin wa++; wd++; end
        end
        chk("starve_first_rd", 32'(first_rd), GUARD ? 32'd4 : 32'hFFFF_FFFF);
        idle(3);

        // Out-of-range read, counter from a fresh reset.
        rst_n_i = 1'b0; idle(1); rst_n_i = 1'b1; idle(1);
        do_read(15'd19200);
        idle(2);
        chk("oor_single", 32'(oor_cnt_o), 32'd1);

        // Read granted, reset the next cycle: the return must vanish.
        do_read(15'd100);
        rst_n_i = 1'b0; idle(1); rst_n_i = 1'b1;
        idle(3);

        // Fill the whole frame, then stream it back one read per cycle.
        for (int a = 0; a <= ADDR_MAX; a++) step(1, 15'(a), 4'($urandom), 0, '0, wg, rg);
        idle(2);
        v0 = vld_seen;
        for (int a = 0; a <= ADDR_MAX; a++) step(0, '0, '0, 1, 15'(a), wg, rg);
        idle(3);
        chk("stream_pulses", vld_seen - v0, 32'(ADDR_MAX + 1));

        // Random mixed traffic with occasional out-of-range and mid-run resets.
        wp = 0; rp = 0; wa = '0; ra = '0; wd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!wp) begin wp = $urandom_range(0, 1) == 1; wa = rand_addr(); wd = 4'($urandom); end
            if (!rp) begin rp = $urandom_range(0, 1) == 1; ra = rand_addr(); end
            rst_n_i = ($urandom_range(0, 399) != 0);
            step(wp, wa, wd, rp, ra, wg, rg);
            if (wg) wp = 0;
            if (rg) rp = 0;
        end
        rst_n_i = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
